// File: rtl/rf_pkg.sv
// Shared defaults and types for the 2-read/1-write register file with scoreboard.
package rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;

  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/rf_reg_en.sv
// One register-file entry: load-enabled flop bank with asynchronous active-low clear.
module rf_reg_en #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register file with one write port, two combinational read ports, optional
// write-through bypass and a per-register pending-write scoreboard.
module regfile_2r1w_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [DATA_W-1:0]    rd_data_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_b,
  output logic                 busy_a,
  output logic                 busy_b,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic                 rsv_ok,
  output logic [(1<<ADDR_W)-1:0] pending
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0]  w_wr_sel;
  logic [DATA_W-1:0] w_q [NREGS];
  logic [NREGS-1:0]  r_pending;
  logic [NREGS-1:0]  w_pending_next;
  logic              w_rsv_acc;
  logic              w_hit_a;
  logic              w_hit_b;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_regs
      assign w_wr_sel[gi] = wr_en && (wr_addr == ADDR_W'(gi));

      rf_reg_en #(
        .W (DATA_W)
      ) u_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_wr_sel[gi]),
        .i_d    (wr_data),
        .o_q    (w_q[gi])
      );
    end

    if (BYPASS) begin : g_bypass
      assign w_hit_a = wr_en && (wr_addr == rd_addr_a);
      assign w_hit_b = wr_en && (wr_addr == rd_addr_b);
    end else begin : g_no_bypass
      assign w_hit_a = 1'b0;
      assign w_hit_b = 1'b0;
    end
  endgenerate

  assign rd_data_a = w_hit_a ? wr_data : w_q[rd_addr_a];
  assign rd_data_b = w_hit_b ? wr_data : w_q[rd_addr_b];
  assign busy_a    = r_pending[rd_addr_a] & ~w_hit_a;
  assign busy_b    = r_pending[rd_addr_b] & ~w_hit_b;

  // A writeback to the pending register frees it in the same cycle, so a
  // back-to-back reservation of the same destination is accepted.
  assign rsv_ok    = ~r_pending[rsv_addr] | (wr_en && (wr_addr == rsv_addr));
  assign w_rsv_acc = rsv_en & rsv_ok;

  always_comb begin
    w_pending_next = r_pending;
    for (int i = 0; i < NREGS; i++) begin
      if (w_rsv_acc && (rsv_addr == ADDR_W'(i))) begin
        w_pending_next[i] = 1'b1;
      end else if (w_wr_sel[i]) begin
        w_pending_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  assign pending = r_pending;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench for regfile_2r1w_sb: one instance with bypass, one without, same stimulus.
module tb_regfile_2r1w_sb;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic        rsv_en;
  logic [2:0]  rsv_addr;

  logic [15:0] rda1, rdb1, rda0, rdb0;
  logic        busya1, busyb1, busya0, busyb0;
  logic        rsvok1, rsvok0;
  logic [7:0]  pend1, pend0;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_2r1w_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda1), .rd_addr_b(rd_addr_b), .rd_data_b(rdb1),
    .busy_a(busya1), .busy_b(busyb1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(rsvok1), .pending(pend1)
  );

  regfile_2r1w_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda0), .rd_addr_b(rd_addr_b), .rd_data_b(rdb0),
    .busy_a(busya0), .busy_b(busyb0), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(rsvok0), .pending(pend0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; rsv_en = 1'b0; rsv_addr = '0;

    // Reset state
    @(negedge clk); #1;
    check("rst_pend1", 32'(pend1), 32'h00);
    check("rst_pend0", 32'(pend0), 32'h00);
    check("rst_rsvok", 32'(rsvok1), 32'h1);
    check("rst_rda", 32'(rda1), 32'h0000);
    check("rst_busy", 32'(busya1), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Write R5 then asynchronous reset between edges
    @(negedge clk); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hABCD;
    @(negedge clk); wr_en = 1'b0; rd_addr_a = 3'd5; #1;
    check("r5_written", 32'(rda0), 32'hABCD);
    #2; rst_n = 1'b0; #1;
    check("arst_rda1", 32'(rda1), 32'h0000);
    check("arst_rda0", 32'(rda0), 32'h0000);
    check("arst_pend", 32'(pend1), 32'h00);
    check("arst_rsvok", 32'(rsvok1), 32'h1);
    @(negedge clk); rst_n = 1'b1;

    // Dual read
    @(negedge clk); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
    @(negedge clk); wr_addr = 3'd6; wr_data = 16'hF00F;
    @(negedge clk); wr_en = 1'b0; rd_addr_a = 3'd2; rd_addr_b = 3'd6; #1;
    check("dual_a1", 32'(rda1), 32'h1234);
    check("dual_b1", 32'(rdb1), 32'hF00F);
    check("dual_a0", 32'(rda0), 32'h1234);
    check("dual_b0", 32'(rdb0), 32'hF00F);

    // Bypass vs no bypass on R3 (old value 0)
    @(negedge clk); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h00FF; rd_addr_a = 3'd3; #1;
    check("byp_rda1", 32'(rda1), 32'h00FF);
    check("nobyp_rda0", 32'(rda0), 32'h0000);
    @(posedge clk); #1;
    check("nobyp_after", 32'(rda0), 32'h00FF);

    // Scoreboard: reserve R4
    @(negedge clk); wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 3'd4; rd_addr_a = 3'd4; #1;
    check("rsv4_ok", 32'(rsvok1), 32'h1);
    @(posedge clk); #1;
    check("rsv4_pend", 32'(pend1), 32'h10);
    check("rsv4_busy", 32'(busya1), 32'h1);
    check("rsv4_again", 32'(rsvok1), 32'h0);
    @(posedge clk); #1;
    check("rsv4_hold", 32'(pend0), 32'h10);
    @(negedge clk); rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h5555; #1;
    check("wb4_busy1", 32'(busya1), 32'h0);
    check("wb4_busy0", 32'(busya0), 32'h1);
    check("wb4_rda1", 32'(rda1), 32'h5555);
    @(posedge clk); #1;
    check("wb4_pend", 32'(pend1), 32'h00);
    check("wb4_busy0n", 32'(busya0), 32'h0);

    // Simultaneous write and reserve on R1 while pending
    @(negedge clk); wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 3'd1;
    @(negedge clk); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hAAAA; #1;
    check("waw_rsvok", 32'(rsvok1), 32'h1);
    @(posedge clk); #1;
    check("waw_pend", 32'(pend1), 32'h02);
    @(negedge clk); wr_en = 1'b0; rsv_en = 1'b0; rd_addr_a = 3'd1; #1;
    check("waw_data", 32'(rda1), 32'hAAAA);
    check("waw_busy", 32'(busya0), 32'h1);

    // Release R1, then write R0 and reserve R7 together
    @(negedge clk); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hBBBB;
    @(negedge clk); wr_addr = 3'd0; wr_data = 16'h0001; rsv_en = 1'b1; rsv_addr = 3'd7;
    @(negedge clk); wr_en = 1'b0; rsv_en = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd1; #1;
    check("r0_data", 32'(rda0), 32'h0001);
    check("r1_data", 32'(rdb0), 32'hBBBB);
    check("r7_pend", 32'(pend1), 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Parametrised register file: one write port, two independent read ports, per-register pending-write scoreboard.
- Sits between the instruction decoder and the datapath ALU.
- Read ports feed the A/B operand latches; write port is driven by the writeback stage.
- Scoreboard lets the controller reserve a destination at issue and stall dependent reads until writeback clears it.
- Adds to the single-port file: async reset, write-through bypass, hazard tracking.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register address width; NREGS = 2**ADDR_W (derived localparam, not overridable)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write register index
wr_data  in  DATA_W  write data
rd_addr_a  in  ADDR_W  read port A index
rd_data_a  out  DATA_W  read port A data
rd_addr_b  in  ADDR_W  read port B index
rd_data_b  out  DATA_W  read port B data
busy_a  out  1  port A source has a pending write
busy_b  out  1  port B source has a pending write
rsv_en  in  1  reserve request: mark rsv_addr pending
rsv_addr  in  ADDR_W  register to reserve
rsv_ok  out  1  reservation accepted this cycle
pending  out  NREGS  scoreboard vector; bit i = register i pending

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All NREGS registers clear to 0 immediately.
  - pending clears to 0.
  - Consequently rd_data_a/b=0, busy_a/b=0, rsv_ok=1 during reset.
  - Reset asserted mid-operation discards any in-flight write and reservation in that cycle.
- Write: at a posedge with wr_en=1, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0, unless a same-address reservation is accepted in the same edge (see below).
  - All registers are general-purpose; index 0 is not hardwired.
- Read: fully combinational, zero latency; rd_data_x = reg[rd_addr_x].
  - BYPASS=1 and wr_en=1 and wr_addr==rd_addr_x: rd_data_x = wr_data (write-through).
  - Both ports may read the same address; both bypass independently.
- busy_x = pending[rd_addr_x] AND NOT (BYPASS AND wr_en AND wr_addr==rd_addr_x).
  - With BYPASS=0, busy_x stays 1 in the writeback cycle and drops the cycle after.
- rsv_ok = NOT pending[rsv_addr] OR (wr_en AND wr_addr==rsv_addr). rsv_ok is combinational and valid regardless of rsv_en.
- Reservation: at a posedge with rsv_en=1 and rsv_ok=1, pending[rsv_addr] <= 1.
  - rsv_en=1 with rsv_ok=0 is ignored; the caller holds the request and retries.
- Simultaneous events on one edge:
  - Write and reserve, same address: data updates and pending ends at 1 (reserve wins, back-to-back WAW).
  - Write and reserve, different addresses: both take effect.
- A write to a non-pending register is legal and leaves pending unchanged (stays 0).
- No X propagation: every output is defined for every input combination.

Decomposition:
- Shared package rf_pkg:
  - RF_DATA_W=16, RF_ADDR_W=3 defaults.
  - Typedefs rf_data_t and rf_addr_t.
- One sub-module, rf_reg_en: a DATA_W-wide register with load enable and async active-low clear, instantiated NREGS times via generate.
- Write decode, read muxes, bypass and scoreboard logic stay in the top module.

Test Plan:
- Reset: write 16'hABCD to R5, then pulse rst_n low between clock edges -> rd_data_a(R5)=0 immediately, pending=8'h00, rsv_ok=1.
- Dual read: write R2=16'h1234 and R6=16'hF00F; set rd_addr_a=2, rd_addr_b=6 -> rd_data_a=16'h1234, rd_data_b=16'hF00F in the same cycle.
- Bypass, BYPASS=1: wr_en=1, wr_addr=3, wr_data=16'h00FF, rd_addr_a=3 before the edge -> rd_data_a=16'h00FF combinationally.
  - Same stimulus with BYPASS=0 -> rd_data_a shows the old value until after the edge.
- Scoreboard: reserve R4 -> pending=8'h10, busy_a=1 with rd_addr_a=4, and a second rsv_en on R4 gives rsv_ok=0 with pending unchanged.
  - Then write R4=16'h5555 -> busy_a=0 in that cycle (BYPASS=1) and pending=8'h00 after the edge.
- Simultaneous WAW: R1 pending; same cycle wr_en to R1 with 16'hAAAA and rsv_en on R1 -> rsv_ok=1; after the edge reg[1]=16'hAAAA and pending[1]=1.
- Same cycle write R0=16'h0001 and reserve R7 -> after the edge reg[0]=16'h0001 and pending=8'h80.
